// File: rtl/fast2slow_pulse_sync_mc.sv
// Multi-channel fast-to-slow pulse synchroniser built on a per-channel toggle req/ack handshake.
// Events that arrive while a channel is busy are counted and replayed, or merged when MERGE=1.
module fast2slow_pulse_sync_mc #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 3,
  parameter bit MERGE       = 1'b0
) (
  input  logic                     rstn,
  input  logic                     clk_fast,
  input  logic                     clk_slow,
  input  logic [N_CH-1:0]          pulse_fast,
  input  logic [N_CH-1:0]          ovf_clr,
  output logic [N_CH-1:0]          pulse_slow,
  output logic [N_CH-1:0]          busy,
  output logic [N_CH-1:0]          overflow,
  output logic [N_CH*PEND_W-1:0]   pend_cnt
);

  // Reset asserts asynchronously in both domains but releases synchronously to each clock.
  logic [1:0] rst_fast_q;
  logic [1:0] rst_slow_q;
  logic       rst_fast_n;
  logic       rst_slow_n;

  always_ff @(posedge clk_fast or negedge rstn) begin
    if (!rstn) rst_fast_q <= '0;
    else       rst_fast_q <= {rst_fast_q[0], 1'b1};
  end

  always_ff @(posedge clk_slow or negedge rstn) begin
    if (!rstn) rst_slow_q <= '0;
    else       rst_slow_q <= {rst_slow_q[0], 1'b1};
  end

  assign rst_fast_n = rst_fast_q[1];
  assign rst_slow_n = rst_slow_q[1];

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic                   pulse_d;
    logic                   req;
    logic                   req_nxt;
    logic                   ack;
    logic                   pulse_q;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [SYNC_STAGES-1:0] req_sync;
    logic [PEND_W-1:0]      pend;
    logic [PEND_W-1:0]      pend_nxt;
    logic                   ovf;
    logic                   ovf_nxt;
    logic                   ev;
    logic                   inflight;
    logic                   cmp;
    logic                   pend_nz;
    logic                   pend_full;

    assign ev        = pulse_fast[ch] & ~pulse_d;
    assign inflight  = req ^ ack_sync[SYNC_STAGES-1];
    // Completion is seen one stage early so a replay toggles req on the very edge inflight would drop.
    assign cmp       = inflight & (ack_sync[SYNC_STAGES-2] == req);
    assign pend_nz   = (pend != '0);
    assign pend_full = &pend;

    always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      req_nxt  = req;
      pend_nxt = pend;
      ovf_nxt  = ovf;
      if (ovf_clr[ch]) ovf_nxt = 1'b0;
      if (cmp) begin
        if (pend_nz) begin
          req_nxt = ~req;
          if (!ev) pend_nxt = pend - PEND_W'(1);
        end else if (ev) begin
          req_nxt = ~req;
        end
      end else if (ev) begin
        if (!inflight && !pend_nz) begin
          req_nxt = ~req;
        end else if (!MERGE) begin
          if (!pend_full) pend_nxt = pend + PEND_W'(1);
          else            ovf_nxt  = 1'b1;
        end
      end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_fast or negedge rst_fast_n) begin
      if (!rst_fast_n) begin
        pulse_d  <= 1'b0;
        req      <= 1'b0;
        ack_sync <= '0;
        pend     <= '0;
        ovf      <= 1'b0;
      end else begin
        pulse_d  <= pulse_fast[ch];
        req      <= req_nxt;
        ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
        pend     <= pend_nxt;
        ovf      <= ovf_nxt;
      end
    end

    // NOTE: synchroniser flops are reset too, otherwise a stale toggle could fire a pulse after reset.
    always_ff @(posedge clk_slow or negedge rst_slow_n) begin
      if (!rst_slow_n) begin
        req_sync <= '0;
        ack      <= 1'b0;
        pulse_q  <= 1'b0;
      end else begin
        req_sync <= {req_sync[SYNC_STAGES-2:0], req};
        ack      <= req_sync[SYNC_STAGES-1];
        pulse_q  <= req_sync[SYNC_STAGES-1] ^ ack;
      end
    end

    assign pulse_slow[ch]                  = pulse_q;
    assign busy[ch]                        = inflight | pend_nz;
    assign overflow[ch]                    = ovf;
    assign pend_cnt[ch*PEND_W +: PEND_W]   = pend;
  end

endmodule

// File: tb/tb_fast2slow_pulse_sync_mc.sv
// Bench: a queueing DUT and a merging DUT share identical stimulus; delivery counts, pend and
// overflow are compared against burst-level expectations derived from channel capacity.
`timescale 1ns/1ps
module tb_fast2slow_pulse_sync_mc;
  localparam int N_CH = 2;
  localparam int SS   = 2;
  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;
  localparam int CAP  = PMAX + 1;

  logic              rstn;
  logic              clk_fast;
  logic              clk_slow;
  logic [N_CH-1:0]   pf;
  logic [N_CH-1:0]   clr;
  logic [N_CH-1:0]   ps0, busy0, ovf0;
  logic [N_CH-1:0]   ps1, busy1, ovf1;
  logic [N_CH*PW-1:0] pend0, pend1;

  int checks = 0;
  int errors = 0;
  int cnt0[N_CH]  = '{default: 0};
  int cnt1[N_CH]  = '{default: 0};
  int wide0[N_CH] = '{default: 0};
  int wide1[N_CH] = '{default: 0};
  logic [N_CH-1:0] prev0 = '0;
  logic [N_CH-1:0] prev1 = '0;

  fast2slow_pulse_sync_mc #(.N_CH(N_CH), .SYNC_STAGES(SS), .PEND_W(PW), .MERGE(1'b0)) u_dut_q (
    .rstn(rstn), .clk_fast(clk_fast), .clk_slow(clk_slow), .pulse_fast(pf), .ovf_clr(clr),
    .pulse_slow(ps0), .busy(busy0), .overflow(ovf0), .pend_cnt(pend0));

  fast2slow_pulse_sync_mc #(.N_CH(N_CH), .SYNC_STAGES(SS), .PEND_W(PW), .MERGE(1'b1)) u_dut_m (
    .rstn(rstn), .clk_fast(clk_fast), .clk_slow(clk_slow), .pulse_fast(pf), .ovf_clr(clr),
    .pulse_slow(ps1), .busy(busy1), .overflow(ovf1), .pend_cnt(pend1));

  initial begin
    clk_fast = 1'b0;
    forever #2.5 clk_fast = ~clk_fast;
  end

  initial begin
    clk_slow = 1'b0;
    #3 clk_slow = 1'b1;
    forever #20 clk_slow = ~clk_slow;
  end

  // Delivery monitor: counts slow pulses and flags any pulse wider than one slow cycle.
  always @(posedge clk_slow) begin
    #1;
    for (int i = 0; i < N_CH; i++) begin
      if (ps0[i]) cnt0[i]++;
      if (ps1[i]) cnt1[i]++;
      if (ps0[i] && prev0[i]) wide0[i]++;
      if (ps1[i] && prev1[i]) wide1[i]++;
    end
    prev0 = ps0;
    prev1 = ps1;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fast_tick();
    @(posedge clk_fast);
    #1;
  endtask

  task automatic slow_tick();
    @(posedge clk_slow);
    #1;
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int pend_of(input logic [N_CH*PW-1:0] v, input int ch);
    return int'(v[ch*PW +: PW]);
  endfunction

  // Waits for busy to drop on both DUTs; at that moment every event must already be delivered.
  task automatic wait_done(input int ch, input int exp0, input int exp1, input int b0, input int b1);
    bit d0 = 1'b0;
    bit d1 = 1'b0;
    for (int t = 0; t < 600 && !(d0 && d1); t++) begin
      fast_tick();
      if (!d0 && !busy0[ch]) begin
        d0 = 1'b1;
        checks++;
        if (cnt0[ch] - b0 !== exp0) begin
          errors++;
          $display("FAIL q_deliv_at_idle ch%0d: got %0d expected %0d", ch, cnt0[ch] - b0, exp0);
        end
      end
      if (!d1 && !busy1[ch]) begin
        d1 = 1'b1;
        checks++;
        if (cnt1[ch] - b1 !== exp1) begin
          errors++;
          $display("FAIL m_deliv_at_idle ch%0d: got %0d expected %0d", ch, cnt1[ch] - b1, exp1);
        end
      end
    end
    checks++;
    if (!(d0 && d1)) begin
      errors++;
      $display("FAIL busy_timeout ch%0d: got q=%0b m=%0b expected both idle", ch, d0, d1);
    end
    repeat (3) slow_tick();
    checks++;
    if (cnt0[ch] - b0 !== exp0 || cnt1[ch] - b1 !== exp1) begin
      errors++;
      $display("FAIL deliv_settled ch%0d: got q=%0d m=%0d expected q=%0d m=%0d",
               ch, cnt0[ch] - b0, cnt1[ch] - b1, exp0, exp1);
    end
  endtask

  // Burst of n single-cycle events two fast cycles apart, all inside one round trip.
  // Queueing DUT: first launches, next PMAX queue, the rest are dropped. Merging DUT: one delivery.
  task automatic run_burst(input int ch, input int n, input int clr_at);
    int  b0[N_CH];
    int  b1[N_CH];
    int  pend_m;
    bit  ovf_m = 1'b0;
    int  oth = 1 - ch;
    for (int i = 0; i < N_CH; i++) begin
      b0[i] = cnt0[i];
      b1[i] = cnt1[i];
    end
    for (int k = 1; k <= n; k++) begin
      pf[ch]  = 1'b1;
      clr[ch] = (k == clr_at);
      fast_tick();
      pf[ch]  = 1'b0;
      clr[ch] = 1'b0;
      pend_m  = min_i(k - 1, PMAX);
      if (k > CAP)          ovf_m = 1'b1;
      else if (k == clr_at) ovf_m = 1'b0;
      checks++;
      if (pend_of(pend0, ch) !== pend_m) begin
        errors++;
        $display("FAIL q_pend ch%0d ev%0d: got %0d expected %0d", ch, k, pend_of(pend0, ch), pend_m);
      end
      checks++;
      if (ovf0[ch] !== ovf_m) begin
        errors++;
        $display("FAIL q_ovf ch%0d ev%0d: got %0b expected %0b", ch, k, ovf0[ch], ovf_m);
      end
      checks++;
      if (busy0[ch] !== 1'b1 || busy1[ch] !== 1'b1) begin
        errors++;
        $display("FAIL busy_burst ch%0d ev%0d: got q=%0b m=%0b expected 1", ch, k, busy0[ch], busy1[ch]);
      end
      checks++;
      if (pend1 !== '0 || ovf1 !== '0) begin
        errors++;
        $display("FAIL m_pend_ovf ev%0d: got pend=%0h ovf=%0b expected 0", k, pend1, ovf1);
      end
      fast_tick();
    end
    wait_done(ch, min_i(n, CAP), 1, b0[ch], b1[ch]);
    checks++;
    if (cnt0[oth] - b0[oth] !== 0 || cnt1[oth] - b1[oth] !== 0) begin
      errors++;
      $display("FAIL other_ch_silent ch%0d: got q=%0d m=%0d expected 0", oth,
               cnt0[oth] - b0[oth], cnt1[oth] - b1[oth]);
    end
    checks++;
    if (ovf0[ch] !== ovf_m) begin
      errors++;
      $display("FAIL q_ovf_sticky ch%0d: got %0b expected %0b", ch, ovf0[ch], ovf_m);
    end
    clr[ch] = 1'b1;
    fast_tick();
    clr[ch] = 1'b0;
    checks++;
    if (ovf0[ch] !== 1'b0) begin
      errors++;
      $display("FAIL q_ovf_clear ch%0d: got %0b expected 0", ch, ovf0[ch]);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    pf   = '0;
    clr  = '0;
    repeat (3) fast_tick();
    checks++;
    if ({ps0, busy0, ovf0, pend0, ps1, busy1, ovf1, pend1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h expected 0", {ps0, busy0, ovf0, pend0, ps1, busy1, ovf1, pend1});
    end
    rstn = 1'b1;
    repeat (4) slow_tick();
    checks++;
    if ({ps0, busy0, ovf0, pend0, ps1, busy1, ovf1, pend1} !== '0) begin
      errors++;
      $display("FAIL post_reset_outputs: got %0h expected 0", {ps0, busy0, ovf0, pend0, ps1, busy1, ovf1, pend1});
    end
  endtask

  task automatic test_single();
    int b0 = cnt0[0];
    int b1 = cnt1[0];
    int c1 = cnt0[1];
    int n  = 0;
    int m  = 0;
    fast_tick();
    checks++;
    if (busy0[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_pre: got %0b expected 0", busy0[0]);
    end
    pf[0] = 1'b1;
    fast_tick();
    pf[0] = 1'b0;
    checks++;
    if (busy0 !== 2'b01 || busy1 !== 2'b01) begin
      errors++;
      $display("FAIL single_busy_rise: got q=%b m=%b expected 01", busy0, busy1);
    end
    do begin
      slow_tick();
      n++;
    end while (!ps0[0] && n < 10);
    checks++;
    if (n < SS + 1 || n > SS + 2 || !ps0[0]) begin
      errors++;
      $display("FAIL single_latency: got %0d slow edges expected %0d..%0d", n, SS + 1, SS + 2);
    end
    checks++;
    if (busy0[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_at_ack: got %0b expected 1", busy0[0]);
    end
    do begin
      fast_tick();
      m++;
    end while (busy0[0] && m < 20);
    checks++;
    if (m < SS || m > SS + 1) begin
      errors++;
      $display("FAIL single_busy_fall: got %0d fast edges expected %0d..%0d", m, SS, SS + 1);
    end
    wait_done(0, 1, 1, b0, b1);
    checks++;
    if (cnt0[1] - c1 !== 0) begin
      errors++;
      $display("FAIL single_ch1_silent: got %0d expected 0", cnt0[1] - c1);
    end
  endtask

  task automatic test_level();
    int ch = $urandom_range(0, N_CH - 1);
    int len = $urandom_range(3, 8);
    int b0 = cnt0[ch];
    int b1 = cnt1[ch];
    pf[ch] = 1'b1;
    for (int k = 0; k < len; k++) begin
      fast_tick();
      checks++;
      if (pend_of(pend0, ch) !== 0 || busy0[ch] !== 1'b1) begin
        errors++;
        $display("FAIL level_hold ch%0d cyc%0d: got pend=%0d busy=%0b expected 0/1",
                 ch, k, pend_of(pend0, ch), busy0[ch]);
      end
    end
    pf[ch] = 1'b0;
    wait_done(ch, 1, 1, b0, b1);
  endtask

  task automatic test_simul();
    int b0[N_CH];
    int b1[N_CH];
    int n = 0;
    for (int i = 0; i < N_CH; i++) begin
      b0[i] = cnt0[i];
      b1[i] = cnt1[i];
    end
    pf = 2'b11;
    fast_tick();
    pf = 2'b00;
    checks++;
    if (busy0 !== 2'b11) begin
      errors++;
      $display("FAIL simul_busy: got %b expected 11", busy0);
    end
    do begin
      slow_tick();
      n++;
    end while (!ps0[1] && n < 10);
    checks++;
    if (ps0[1] !== 1'b1) begin
      errors++;
      $display("FAIL simul_first_deliv: got %0b expected 1", ps0[1]);
    end
    // Ack toggled on that slow edge; the second fast edge after it is the completion edge.
    fast_tick();
    pf[1] = 1'b1;
    fast_tick();
    pf[1] = 1'b0;
    checks++;
    if (busy0[1] !== 1'b1 || busy1[1] !== 1'b1 || pend_of(pend0, 1) !== 0) begin
      errors++;
      $display("FAIL simul_relaunch: got busy q=%0b m=%0b pend=%0d expected 1 1 0",
               busy0[1], busy1[1], pend_of(pend0, 1));
    end
    wait_done(1, 2, 2, b0[1], b1[1]);
    checks++;
    if (cnt0[0] - b0[0] !== 1 || cnt1[0] - b1[0] !== 1) begin
      errors++;
      $display("FAIL simul_ch0_deliv: got q=%0d m=%0d expected 1", cnt0[0] - b0[0], cnt1[0] - b1[0]);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    int r1;
    for (int k = 0; k < 3; k++) begin
      pf[0] = 1'b1;
      fast_tick();
      pf[0] = 1'b0;
      fast_tick();
    end
    checks++;
    if (pend_of(pend0, 0) !== 2 || busy0[0] !== 1'b1) begin
      errors++;
      $display("FAIL rmid_setup: got pend=%0d busy=%0b expected 2 1", pend_of(pend0, 0), busy0[0]);
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({ps0, busy0, ovf0, pend0, ps1, busy1, ovf1, pend1} !== '0) begin
      errors++;
      $display("FAIL rmid_async_clear: got %0h expected 0", {ps0, busy0, ovf0, pend0, ps1, busy1, ovf1, pend1});
    end
    r0 = cnt0[0];
    r1 = cnt1[0];
    repeat (3) fast_tick();
    rstn = 1'b1;
    repeat (12) slow_tick();
    checks++;
    if (cnt0[0] - r0 !== 0 || cnt1[0] - r1 !== 0 || busy0 !== '0) begin
      errors++;
      $display("FAIL rmid_no_spurious: got q=%0d m=%0d busy=%b expected 0", cnt0[0] - r0, cnt1[0] - r1, busy0);
    end
    r0 = cnt0[0];
    r1 = cnt1[0];
    pf[0] = 1'b1;
    fast_tick();
    pf[0] = 1'b0;
    wait_done(0, 1, 1, r0, r1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int ch  = $urandom_range(0, N_CH - 1);
      int n   = $urandom_range(1, 6);
      int ca  = $urandom_range(0, n);
      int gap = $urandom_range(0, 7);
      repeat (gap) fast_tick();
      run_burst(ch, n, ca);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    run_burst(0, 3, 0);
    run_burst(0, 5, 0);
    run_burst(0, 6, 6);
    test_level();
    test_simul();
    test_reset_mid();
    test_random();
    for (int i = 0; i < N_CH; i++) begin
      checks++;
      if (wide0[i] !== 0 || wide1[i] !== 0) begin
        errors++;
        $display("FAIL pulse_width ch%0d: got q=%0d m=%0d wide pulses expected 0", i, wide0[i], wide1[i]);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
